// File: rtl/ram_mbist_pkg.sv
// ram_mbist_pkg
// Shared definitions for the single-port RAM March C- BIST:
//   - controller state encoding
//   - march element encoding (address direction, op sequence, data polarity)
//   - element count and the element table lookup
package ram_mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mbist_state_e;

    // One march element. Every element starts with op "a"; two-op elements
    // follow it with a write of polarity pol_b at the same address.
    typedef struct packed {
        logic down;      // walk addresses N-1..0
        logic two_op;    // element has a second op per address
        logic rd_first;  // op "a" is a read (otherwise a write)
        logic pol_a;     // background polarity of op "a"
        logic pol_b;     // background polarity written by op "b"
    } march_elem_t;

    localparam int unsigned NumElem  = 6;
    localparam int unsigned ElemIdxW = 3;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic march_elem_t march_elem(input logic [ElemIdxW-1:0] idx);
        march_elem_t e;
        case (idx)
            3'd0:    e = '{down: 1'b0, two_op: 1'b0, rd_first: 1'b0, pol_a: 1'b0, pol_b: 1'b0};
            3'd1:    e = '{down: 1'b0, two_op: 1'b1, rd_first: 1'b1, pol_a: 1'b0, pol_b: 1'b1};
            3'd2:    e = '{down: 1'b0, two_op: 1'b1, rd_first: 1'b1, pol_a: 1'b1, pol_b: 1'b0};
            3'd3:    e = '{down: 1'b1, two_op: 1'b1, rd_first: 1'b1, pol_a: 1'b0, pol_b: 1'b1};
            3'd4:    e = '{down: 1'b1, two_op: 1'b1, rd_first: 1'b1, pol_a: 1'b1, pol_b: 1'b0};
            3'd5:    e = '{down: 1'b0, two_op: 1'b0, rd_first: 1'b1, pol_a: 1'b0, pol_b: 1'b0};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ram_mbist_cmp.sv
// ram_mbist_cmp
// Read-data compare with first-fail capture. The read's expected value and
// compare flag arrive registered alongside the RAM command; they are held one
// more cycle here so they line up with ram_q_i, which the RAM returns one
// cycle after it samples the read.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr_i           clear the capture (test accepted)
//   rd_en_i         a read is on the RAM pins this cycle
//   rd_addr_i       address of that read
//   rd_exp_i        expected data of that read
//   ram_q_i         RAM read data
//   fail_o          sticky mismatch flag
//   fail_addr_o     address of the first mismatch
//   fail_data_o     ram_q XOR expected at the first mismatch
module ram_mbist_cmp
    import ram_mbist_pkg::*;
#(
    parameter int unsigned AddressWidth = 10,
    parameter int unsigned DataWidth    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    rd_en_i,
    input  logic [AddressWidth-1:0] rd_addr_i,
    input  logic [DataWidth-1:0]    rd_exp_i,
    input  logic [DataWidth-1:0]    ram_q_i,
    output logic                    fail_o,
    output logic [AddressWidth-1:0] fail_addr_o,
    output logic [DataWidth-1:0]    fail_data_o
);

    logic                    en_q;
    logic [AddressWidth-1:0] addr_q;
    logic [DataWidth-1:0]    exp_q;
    logic                    fail_q;
    logic [AddressWidth-1:0] fail_addr_q;
    logic [DataWidth-1:0]    fail_data_q;
    logic [DataWidth-1:0]    diff;

    assign diff = ram_q_i ^ exp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= 1'b0;
            addr_q      <= '0;
            exp_q       <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            en_q   <= rd_en_i;
            addr_q <= rd_addr_i;
            exp_q  <= rd_exp_i;
            if (clr_i) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_data_q <= '0;
            end else if (en_q && (diff != '0) && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= addr_q;
                fail_data_q <= diff;
            end
        end
    end

    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;

endmodule

// File: rtl/ram_1rw_mbist.sv
// ram_1rw_mbist
// March C- memory BIST controller for a single-port RAM. One RAM op per
// cycle, 10N ops per pass, all RAM pins registered.
// Optional macro RAM_MBIST_CHECKERBOARD_EN: append a second pass whose
// background "0" is the checkerboard ..0101 (LSB 1).
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | issuing march ops, one per cycle
// DRAIN | pins idle, last read being compared
// DONE  | result valid (done sticky), waiting for start
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start                       level-sampled test request (ignored while busy)
//   busy, done                  RUN/DRAIN indicator, sticky completion
//   fail, fail_addr, fail_data  sticky first-mismatch capture
//   ram_addr, ram_d, ram_wr_n, ram_ce_n, ram_wr_mask_n, ram_cmbist  RAM drive
//   ram_q                       RAM read data (one cycle after the read)
module ram_1rw_mbist #(
    parameter int unsigned AddressWidth = 10,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned wrMaskWidth  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [AddressWidth-1:0] fail_addr,
    output logic [DataWidth-1:0]    fail_data,
    output logic [AddressWidth-1:0] ram_addr,
    output logic [DataWidth-1:0]    ram_d,
    output logic                    ram_wr_n,
    output logic                    ram_ce_n,
    output logic [wrMaskWidth-1:0]  ram_wr_mask_n,
    output logic                    ram_cmbist,
    input  logic [DataWidth-1:0]    ram_q
);
    import ram_mbist_pkg::*;

`ifdef RAM_MBIST_CHECKERBOARD_EN
    function automatic logic [DataWidth-1:0] ckbd_bg();
        logic [DataWidth-1:0] v;
        for (int i = 0; i < int'(DataWidth); i++) v[i] = (i % 2 == 0);
        return v;
    endfunction
    localparam logic [DataWidth-1:0] CkbdBg = ckbd_bg();
    logic pass_q, pass_d;
`endif

    mbist_state_e            state_q;
    logic [ElemIdxW-1:0]     elem_q, elem_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic                    phase_q, phase_d;
    logic                    last_q;
    logic                    busy_q, done_q;
    logic [AddressWidth-1:0] ram_addr_q;
    logic [DataWidth-1:0]    ram_d_q;
    logic                    ram_wr_n_q, ram_ce_n_q;
    logic [wrMaskWidth-1:0]  ram_mask_n_q;
    logic                    cmp_en_q;
    logic [DataWidth-1:0]    cmp_exp_q;

    march_elem_t             cur, nxt;
    logic                    op_rd, op_pol, addr_end, final_op;
    logic [DataWidth-1:0]    bg0, op_data;
    logic                    accept, issue;

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign issue  = accept || ((state_q == ST_RUN) && !last_q);

    // Decode the op at the current march position and the position after it.
    // The counters always hold the next op to issue and rest at position 0.
    always_comb begin
        cur      = march_elem(elem_q);
        op_rd    = cur.rd_first && !phase_q;
        op_pol   = phase_q ? cur.pol_b : cur.pol_a;
        addr_end = cur.down ? (addr_q == '0) : (addr_q == {AddressWidth{1'b1}});
`ifdef RAM_MBIST_CHECKERBOARD_EN
        bg0      = pass_q ? CkbdBg : '0;
        pass_d   = pass_q;
`else
        bg0      = '0;
`endif
        op_data  = op_pol ? ~bg0 : bg0;
        elem_d   = elem_q;
        addr_d   = addr_q;
        phase_d  = 1'b0;
        final_op = 1'b0;
        nxt      = cur;
        if (phase_q != cur.two_op) begin
            phase_d = 1'b1;
        end else if (!addr_end) begin
            addr_d = cur.down ? addr_q - AddressWidth'(1) : addr_q + AddressWidth'(1);
        end else begin
            if (elem_q == ElemIdxW'(NumElem - 1)) begin
                elem_d = '0;
`ifdef RAM_MBIST_CHECKERBOARD_EN
                pass_d   = ~pass_q;
                final_op = pass_q;
`else
                final_op = 1'b1;
`endif
            end else begin
                elem_d = elem_q + ElemIdxW'(1);
            end
            // Jump straight to the next element's first address: no gap cycle.
            nxt    = march_elem(elem_d);
            addr_d = nxt.down ? {AddressWidth{1'b1}} : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            elem_q       <= '0;
            addr_q       <= '0;
            phase_q      <= 1'b0;
            last_q       <= 1'b0;
`ifdef RAM_MBIST_CHECKERBOARD_EN
            pass_q       <= 1'b0;
`endif
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ram_addr_q   <= '0;
            ram_d_q      <= '0;
            ram_wr_n_q   <= 1'b1;
            ram_ce_n_q   <= 1'b1;
            ram_mask_n_q <= '1;
            cmp_en_q     <= 1'b0;
            cmp_exp_q    <= '0;
        end else begin
            ram_addr_q   <= '0;
            ram_d_q      <= '0;
            ram_wr_n_q   <= 1'b1;
            ram_ce_n_q   <= 1'b1;
            ram_mask_n_q <= '1;
            cmp_en_q     <= 1'b0;
            cmp_exp_q    <= '0;
            if (issue) begin
                ram_ce_n_q   <= 1'b0;
                ram_wr_n_q   <= op_rd;
                ram_mask_n_q <= {wrMaskWidth{op_rd}};
                ram_addr_q   <= addr_q;
                ram_d_q      <= op_rd ? '0 : op_data;
                cmp_en_q     <= op_rd;
                cmp_exp_q    <= op_rd ? op_data : '0;
                elem_q       <= elem_d;
                addr_q       <= addr_d;
                phase_q      <= phase_d;
                last_q       <= final_op;
`ifdef RAM_MBIST_CHECKERBOARD_EN
                pass_q       <= pass_d;
`endif
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (last_q) begin
                        state_q <= ST_DRAIN;
                        last_q  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ram_mbist_cmp #(
        .AddressWidth(AddressWidth),
        .DataWidth   (DataWidth)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (accept),
        .rd_en_i    (cmp_en_q),
        .rd_addr_i  (ram_addr_q),
        .rd_exp_i   (cmp_exp_q),
        .ram_q_i    (ram_q),
        .fail_o     (fail),
        .fail_addr_o(fail_addr),
        .fail_data_o(fail_data)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign ram_addr      = ram_addr_q;
    assign ram_d         = ram_d_q;
    assign ram_wr_n      = ram_wr_n_q;
    assign ram_ce_n      = ram_ce_n_q;
    assign ram_wr_mask_n = ram_mask_n_q;
    assign ram_cmbist    = busy_q;

endmodule
